// File: rtl/i2s_rx_stream.sv
// i2s_rx_stream
//   Captures each stereo frame from the I2S receiver's parallel outputs on the
//   rising edge of LRCK. Stores it in a small first-word-fall-through FIFO.
//   Offers the oldest frame to DSP logic as a valid/ready stream.
//   Everything runs in the MCLK domain. LRCK and the parallel words are
//   already synchronous to MCLK, so they need no synchronisers.
//
// Parameters
//   WIDTH  bits per channel word
//   DEPTH  FIFO depth in stereo frames (power of two, 2..256)
//
// Ports
//   mclk     master clock; all logic runs on its rising edge
//   arstn    asynchronous active-low reset
//   lrck     word clock from the transceiver
//   pld/prd  left/right word; held stable around the LRCK rising edge
//   m_valid  head frame valid
//   m_ready  consumer accepts the head frame
//   m_ldata  head frame, left word
//   m_rdata  head frame, right word
//   level    frames currently stored
//   ovf      sticky overflow flag
//   ovf_clr  clears ovf and ovf_cnt; wins over a same-cycle drop
//   ovf_cnt  saturating dropped-frame count
//
// Build option
//   I2S_RX_STREAM_OVF_CNT_EN  when defined, ovf_cnt counts dropped frames.
//                             Otherwise ovf_cnt is tied to zero.
module i2s_rx_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     mclk,
  input  logic                     arstn,
  input  logic                     lrck,
  input  logic [WIDTH-1:0]         pld,
  input  logic [WIDTH-1:0]         prd,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_ldata,
  output logic [WIDTH-1:0]         m_rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr,
  output logic [15:0]              ovf_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic               lrck_q;
  logic               cap;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  // lrck_q resets high, so an LRCK already high at reset release is not
  // mistaken for a fresh rising edge.
  assign cap  = lrck & ~lrck_q;
  assign full = (level == DEPTH_L);
  assign pop  = m_valid & m_ready;
  // When the FIFO is full, a same-cycle pop frees the slot being written.
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  assign m_valid = (level != '0);
  assign m_ldata = mem[rptr][2*WIDTH-1:WIDTH];
  assign m_rdata = mem[rptr][WIDTH-1:0];

  // Frame storage is data only; it is never reset.
  always_ff @(posedge mclk) begin
    if (push) begin
      mem[wptr] <= {pld, prd};
    end
  end

  // Control: edge detect, pointers, level and overflow flag.
  always_ff @(posedge mclk or negedge arstn) begin
    if (!arstn) begin
      lrck_q <= 1'b1;
      wptr   <= '0;
      rptr   <= '0;
      level  <= '0;
      ovf    <= 1'b0;
    end else begin
      lrck_q <= lrck;
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end
      if (ovf_clr) begin
        ovf <= 1'b0;
      end else if (drop) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef I2S_RX_STREAM_OVF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] ovf_cnt_q;

  always_ff @(posedge mclk or negedge arstn) begin
    if (!arstn) begin
      ovf_cnt_q <= '0;
    end else if (ovf_clr) begin
      ovf_cnt_q <= '0;
    end else if (drop) begin
      ovf_cnt_q <= sat_inc16(ovf_cnt_q);
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`else
  assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: doc/i2s_rx_stream.md
# i2s_rx_stream

Downstream stage of the I2S transceiver: captures each completed stereo frame from the receiver's parallel outputs (left/right words) on the rising edge of LRCK and pushes it into a small synchronous FIFO. DSP logic consumes the FIFO via a valid/ready stream. Runs entirely in the MCLK domain, so LRCK and the parallel words need no synchronisers.

## Interface
- WIDTH, 32: bits per channel word; matches the transceiver WIDTH.
- DEPTH, 8: FIFO depth in stereo frames; power of two, 2..256.

Ports:
- mclk  in  1  master clock; all logic on its rising edge.
- arstn  in  1  asynchronous active-low reset.
- lrck  in  1  word clock from the transceiver, generated from mclk.
- pld  in  WIDTH  left word from the transceiver's left parallel output.
- prd  in  WIDTH  right word from the transceiver's right parallel output.
- m_valid  out  1  head frame valid.
- m_ready  in  1  consumer accepts the head frame.
- m_ldata  out  WIDTH  head frame, left word.
- m_rdata  out  WIDTH  head frame, right word.
- level  out  $clog2(DEPTH)+1  frames currently stored.
- ovf  out  1  sticky overflow flag.
- ovf_clr  in  1  clears ovf (and ovf_cnt).
- ovf_cnt  out  16  dropped-frame count; see Configuration.

## Operation
- Edge detect: lrck_q <= lrck each cycle.
  - cap = lrck & ~lrck_q.
  - lrck_q resets to 1, so no capture fires for LRCK already high at reset release.
- Capture: in a cycle with cap=1, {pld, prd} is the write word. The transceiver holds pld/prd stable for a whole frame around the LRCK rising edge.
- Push: push = cap & (~full | pop), where pop = m_valid & m_ready.
  - A pop and a push in the same cycle while full are both accepted. level is unchanged and no drop occurs.
- Drop: cap & full & ~pop discards the frame and sets ovf. FIFO contents are untouched.
- Read: first-word-fall-through.
  - m_ldata/m_rdata show the oldest stored frame while m_valid=1.
  - Both are don't-care while m_valid=0.
- m_valid = (level != 0).
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. level is a separate up/down counter:
  - +1 on push only; −1 on pop only; unchanged on both or neither.
- Flags: full = (level == DEPTH); empty = (level == 0).
- ovf_clr has priority over a same-cycle set: ovf ends at 0 and the drop is not counted.
- Reset values (asynchronous, immediate):
  - m_valid=0, level=0, ovf=0, ovf_cnt=0.
  - Pointers 0, lrck_q=1.
  - FIFO RAM is not reset.
- Reset asserted mid-operation flushes all stored frames. The first capture after release needs a fresh LRCK 0→1 transition.

## Timing
- Capture latency: if a push occurs at rising edge N on an empty FIFO, m_valid=1 and data are valid after edge N. Zero added cycles beyond the write.
- A pop at edge N makes the next frame visible after edge N; m_valid can stay high continuously.
- level, ovf and ovf_cnt update at the same edge as the push, pop or drop that causes them.
- m_ready is not sampled while m_valid=0.
- Throughput: one push per LRCK period, one pop per mclk cycle.

## Configuration
- Macro: I2S_RX_STREAM_OVF_CNT_EN.
- Defined:
  - ovf_cnt increments by 1 on every dropped frame, saturating at 16'hFFFF.
  - ovf_clr zeroes it.
- Undefined: ovf_cnt is tied to 16'h0000 and no counter logic is built. ovf behaves identically in both builds.

## Test plan
- Reset/first frame:
  - Hold arstn low 20 ns with lrck=0, then release.
  - Drive pld=32'h00000001, prd=32'h80000000, then lrck 0→1.
  - Expect m_valid=1 after that edge, with m_ldata/m_rdata equal to the driven words and level=1.
- Loopback stream:
  - Transceiver in loopback with MCLK/LRCK=256, pld incrementing each frame, m_ready=1.
  - Expect the consumed left words to be strictly consecutive, level ≤1 and ovf=0 across 20 frames.
- Fill/overflow:
  - m_ready=0, 10 frames.
  - Expect level=8 and frames 0..7 retained; frames 8 and 9 dropped.
  - Expect ovf=1, and ovf_cnt=2 with the macro defined (0 without).
- Full with simultaneous pop:
  - FIFO full; pulse m_ready for exactly the cap cycle.
  - Expect frame 0 popped, the new frame written, level=8 and ovf unchanged.
- Clear priority: assert ovf_clr in the same cycle as a drop. Expect ovf=0 and ovf_cnt=0 afterwards.
- Reset mid-stream:
  - With level=5, pulse arstn low while lrck=1.
  - Expect level=0 and m_valid=0 immediately, and no capture until the next LRCK rising edge.
